// File: rtl/uart_ctrl_arbiter.sv
// rtl/uart_ctrl_arbiter.sv - round-robin arbiter sharing the UART command register between two requesters
//
// Purpose:
//   Two requesters (e.g. CPU bus and sensor sequencer) compete for the UART
//   control/command register. One command is issued per transaction. The
//   arbiter then waits for the UART to signal completion, or gives up after
//   TIMEOUT_CYCLES, and acks the owning requester. Ties alternate round-robin.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous reset, active-high
//   req1_i       requester 1 request level, held until ack1_o
//   data1_i      requester 1 command, stable while req1_i=1
//   req2_i       requester 2 request level, held until ack2_o
//   data2_i      requester 2 command, stable while req2_i=1
//   uart_busy_i  UART busy, blocks new grants only
//   uart_done_i  UART command complete, 1-cycle pulse, honoured only in WAIT
//   cmd_o        command to UART, zero except while cmd_valid_o=1
//   cmd_valid_o  command write strobe, one cycle per transaction
//   grant_o      one-hot owner {req2,req1}, 00 when idle
//   ack1_o       requester 1 transaction finished, 1-cycle pulse
//   ack2_o       requester 2 transaction finished, 1-cycle pulse
//   timeout_o    pulses together with the ack when the UART never reported done

module uart_ctrl_arbiter #(
  parameter int  DATA_W         = 32,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic              req2_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              uart_busy_i,
  input  logic              uart_done_i,
  output logic [DATA_W-1:0] cmd_o,
  output logic              cmd_valid_o,
  output logic [1:0]        grant_o,
  output logic              ack1_o,
  output logic              ack2_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last2;   // 1: requester 2 owned the previous transaction
  logic              r_owner2;  // 1: requester 2 owns the current transaction
  logic [DATA_W-1:0] r_cmd;
  logic              r_cmd_valid;
  logic [1:0]        r_grant;
  logic              r_ack1;
  logic              r_ack2;
  logic              r_timeout;

  logic w_any_req;
  logic w_pick2;
  logic w_cnt_last;

  assign w_any_req  = req1_i | req2_i;
  // Requester 2 wins when alone, or on a tie when requester 1 went last.
  assign w_pick2    = req2_i & (~req1_i | ~r_last2);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last2     <= 1'b1;  // pretend requester 2 went last so requester 1 wins the first tie
      r_owner2    <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_grant     <= 2'b00;
      r_ack1      <= 1'b0;
      r_ack2      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // Strobe-style outputs default low and are raised only for the one
      // cycle spent in the state that owns them.
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_ack1      <= 1'b0;
      r_ack2      <= 1'b0;
      r_timeout   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!uart_busy_i && w_any_req) begin
            r_owner2    <= w_pick2;
            r_cmd       <= w_pick2 ? data2_i : data1_i;
            r_cmd_valid <= 1'b1;
            r_grant     <= w_pick2 ? 2'b10 : 2'b01;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A done arriving on the same edge as the last count still counts
          // as a normal completion.
          if (uart_done_i || w_cnt_last) begin
            r_ack1    <= ~r_owner2;
            r_ack2    <= r_owner2;
            r_timeout <= ~uart_done_i;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_last2 <= r_owner2;
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end

        default: begin
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_o       = r_cmd;
  assign cmd_valid_o = r_cmd_valid;
  assign grant_o     = r_grant;
  assign ack1_o      = r_ack1;
  assign ack2_o      = r_ack2;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_uart_ctrl_arbiter.sv
// tb/tb_uart_ctrl_arbiter.sv - self-checking bench for uart_ctrl_arbiter

module tb_uart_ctrl_arbiter;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        req1;
  logic [31:0] data1;
  logic        req2;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [1:0]  grant;
  logic        ack1;
  logic        ack2;
  logic        timeout;

  int total;
  int bad;

  uart_ctrl_arbiter #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req1_i      (req1),
    .data1_i     (data1),
    .req2_i      (req2),
    .data2_i     (data2),
    .uart_busy_i (busy),
    .uart_done_i (done),
    .cmd_o       (cmd),
    .cmd_valid_o (cmd_valid),
    .grant_o     (grant),
    .ack1_o      (ack1),
    .ack2_o      (ack2),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic coin(int unsigned n);
    return ($urandom % n) == 0;
  endfunction

  task automatic test_reset;
    rst = 1; req1 = 0; req2 = 0; busy = 0; done = 0; data1 = '0; data2 = '0;
    tick;
    tick;
    total++;
    if ({cmd_valid, cmd, grant, ack1, ack2, timeout} !== 38'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {cmd_valid, cmd, grant, ack1, ack2, timeout});
    end
    rst = 0;
    tick;
    total++;
    if ({cmd_valid, grant, ack1, ack2, timeout} !== 6'h0) begin
      bad++; $display("FAIL reset_idle: got %h want 0", {cmd_valid, grant, ack1, ack2, timeout});
    end
  endtask

  task automatic test_single;
    int ack_n, n_ack1, n_ack2, n_strobe, n_to;
    req1 = 1; data1 = 32'hA5A5_0001;
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b01, 32'hA5A5_0001}) begin
      bad++; $display("FAIL single_strobe: got %h want %h", {cmd_valid, grant, cmd}, {1'b1, 2'b01, 32'hA5A5_0001});
    end
    data1 = 32'hDEAD_BEEF;
    ack_n = -1; n_ack1 = 0; n_ack2 = 0; n_strobe = 0; n_to = 0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (cmd_valid) n_strobe++;
      if (ack1) begin n_ack1++; ack_n = n; req1 = 0; end
      if (ack2) n_ack2++;
      if (timeout) n_to++;
      done = (n == 5);
    end
    done = 0;
    total++;
    if (n_strobe !== 0) begin bad++; $display("FAIL single_extra_strobe: got %0d want 0", n_strobe); end
    total++;
    if (n_ack1 !== 1) begin bad++; $display("FAIL single_ack1_count: got %0d want 1", n_ack1); end
    total++;
    if (ack_n !== 6) begin bad++; $display("FAIL single_ack1_latency: got %0d want 6", ack_n); end
    total++;
    if (n_ack2 !== 0) begin bad++; $display("FAIL single_ack2_count: got %0d want 0", n_ack2); end
    total++;
    if (n_to !== 0) begin bad++; $display("FAIL single_timeout: got %0d want 0", n_to); end
    total++;
    if ({cmd, grant} !== 34'h0) begin bad++; $display("FAIL single_idle_after: got %h want 0", {cmd, grant}); end
  endtask

  task automatic test_alternation;
    int          s_cyc[4];
    int          a_cyc[4];
    logic [1:0]  g[4];
    logic [31:0] c[4];
    logic [1:0]  a[4];
    int          ns, na, ss;
    for (int i = 0; i < 4; i++) begin s_cyc[i] = 0; a_cyc[i] = 0; g[i] = 0; c[i] = 0; a[i] = 0; end
    rst = 1; req1 = 1; req2 = 1; data1 = 32'h1111_0001; data2 = 32'h2222_0002;
    tick;
    rst = 0; ns = 0; na = 0; ss = 100;
    for (int cyc = 0; cyc < 100 && na < 4; cyc++) begin
      tick;
      if (cmd_valid) begin
        if (ns < 4) begin s_cyc[ns] = cyc; g[ns] = grant; c[ns] = cmd; end
        ns++; ss = 0;
      end else begin
        ss++;
      end
      if (ack1 || ack2) begin
        if (na < 4) begin a_cyc[na] = cyc; a[na] = {ack2, ack1}; end
        na++;
      end
      done = (ss == 3);
    end
    req1 = 0; req2 = 0; done = 0;
    tick;
    total++;
    if (ns !== 4 || na !== 4) begin bad++; $display("FAIL alt_counts: got strobes=%0d acks=%0d want 4 4", ns, na); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g[i] !== ((i % 2) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL alt_grant[%0d]: got %b want %b", i, g[i], ((i % 2) ? 2'b10 : 2'b01));
      end
      total++;
      if (c[i] !== ((i % 2) ? 32'h2222_0002 : 32'h1111_0001)) begin
        bad++; $display("FAIL alt_cmd[%0d]: got %h", i, c[i]);
      end
      total++;
      if (a[i] !== g[i] || a_cyc[i] - s_cyc[i] !== 4) begin
        bad++; $display("FAIL alt_ack[%0d]: got ack=%b lat=%0d want ack=%b lat=4", i, a[i], a_cyc[i] - s_cyc[i], g[i]);
      end
      if (i > 0) begin
        total++;
        if (s_cyc[i] - a_cyc[i-1] !== 2) begin
          bad++; $display("FAIL alt_idle_gap[%0d]: got %0d want 2", i, s_cyc[i] - a_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_busy;
    int n_strobe, got;
    busy = 1; req2 = 1; data2 = 32'hB0B0_0003; n_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (cmd_valid || grant != 2'b00) n_strobe++;
    end
    total++;
    if (n_strobe !== 0) begin bad++; $display("FAIL busy_blocked: got %0d grant cycles want 0", n_strobe); end
    busy = 0;
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b10, 32'hB0B0_0003}) begin
      bad++; $display("FAIL busy_release_strobe: got %h want %h", {cmd_valid, grant, cmd}, {1'b1, 2'b10, 32'hB0B0_0003});
    end
    busy = 1; got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (ack2) begin got = n; break; end
      done = (n == 2);
    end
    done = 0;
    total++;
    if (got !== 3 || timeout !== 1'b0) begin
      bad++; $display("FAIL busy_in_wait_ack: got lat=%0d timeout=%b want lat=3 timeout=0", got, timeout);
    end
    req2 = 0; busy = 0;
    tick;
  endtask

  task automatic test_timeout;
    int got;
    req1 = 1; data1 = 32'h7E57_0004;
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b01, 32'h7E57_0004}) begin
      bad++; $display("FAIL to_strobe: got %h", {cmd_valid, grant, cmd});
    end
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (ack1 || ack2 || timeout) begin got = n; break; end
    end
    total++;
    if (got !== T + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", got, T + 1); end
    total++;
    if ({ack1, ack2, timeout} !== 3'b101) begin
      bad++; $display("FAIL to_flags: got %b want 101", {ack1, ack2, timeout});
    end
    req2 = 1; data2 = 32'h7E57_0005;
    tick;
    total++;
    if ({cmd_valid, grant} !== 3'b000) begin bad++; $display("FAIL to_idle_gap: got %b want 000", {cmd_valid, grant}); end
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b10, 32'h7E57_0005}) begin
      bad++; $display("FAIL to_next_tie: got %h want %h", {cmd_valid, grant, cmd}, {1'b1, 2'b10, 32'h7E57_0005});
    end
    req1 = 0; got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (ack2) begin got = n; break; end
      done = (n == 1);
    end
    done = 0;
    total++;
    if (got !== 2 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_second_ack: got lat=%0d timeout=%b want lat=2 timeout=0", got, timeout);
    end
    req2 = 0;
    tick;
  endtask

  task automatic test_reset_in_wait;
    int n_bad;
    req1 = 1; data1 = 32'h5E70_0005;
    tick;
    tick;
    tick;
    rst = 1;
    tick;
    total++;
    if ({cmd_valid, cmd, grant, ack1, ack2, timeout} !== 38'h0) begin
      bad++; $display("FAIL rst_wait_outputs: got %h want 0", {cmd_valid, cmd, grant, ack1, ack2, timeout});
    end
    rst = 0; req1 = 0; done = 1;
    tick;
    done = 0;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if ({cmd_valid, cmd, grant, ack1, ack2, timeout} !== 38'h0) n_bad++;
      tick;
    end
    total++;
    if (n_bad !== 0) begin bad++; $display("FAIL rst_wait_no_ack: got %0d active cycles want 0", n_bad); end
  endtask

  task automatic test_done_boundary;
    int n_early, got;
    req1 = 1; req2 = 1; data1 = 32'hB00D_0006; data2 = 32'hB00D_0007;
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b01, 32'hB00D_0006}) begin
      bad++; $display("FAIL edge_first_tie: got %h want %h", {cmd_valid, grant, cmd}, {1'b1, 2'b01, 32'hB00D_0006});
    end
    n_early = 0;
    for (int n = 1; n <= T; n++) begin
      tick;
      if (ack1 || ack2 || timeout) n_early++;
      done = (n == T);
    end
    tick;
    done = 0;
    total++;
    if (n_early !== 0) begin bad++; $display("FAIL edge_early_ack: got %0d want 0", n_early); end
    total++;
    if ({ack1, ack2, timeout} !== 3'b100) begin
      bad++; $display("FAIL edge_done_wins: got %b want 100", {ack1, ack2, timeout});
    end
    req1 = 0;
    tick;
    tick;
    total++;
    if ({cmd_valid, grant, cmd} !== {1'b1, 2'b10, 32'hB00D_0007}) begin
      bad++; $display("FAIL edge_second_grant: got %h", {cmd_valid, grant, cmd});
    end
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (ack2) begin got = n; break; end
      done = (n == 1);
    end
    done = 0;
    total++;
    if (got !== 2) begin bad++; $display("FAIL edge_second_ack: got %0d want 2", got); end
    req2 = 0;
    tick;
  endtask

  // Transaction-level model: the bench decides every input, so it predicts
  // the winner from its own last-owner record and the ack time from the
  // done delay it chose (done delay beyond the limit means timeout).
  task automatic test_random;
    logic        own2, exp_now, granted, m_last2;
    logic [31:0] exp_data;
    logic [1:0]  exp_g;
    int          d, exp_n, cyc;
    rst = 1; req1 = 0; req2 = 0; busy = 0; done = 0;
    tick;
    rst = 0; m_last2 = 1'b1; exp_g = 2'b00; own2 = 1'b0; exp_data = '0;
    for (int it = 0; it < 60; it++) begin
      granted = 0; cyc = 0;
      while (!granted && cyc < 50) begin
        if (!req1 && coin(2)) begin req1 = 1; data1 = $urandom; end
        if (!req2 && coin(2)) begin req2 = 1; data2 = $urandom; end
        busy = (cyc < 40) && coin(3);
        done = coin(4);
        exp_now = !busy && (req1 || req2);
        if (exp_now) begin
          own2 = req2 && (!req1 || !m_last2);
          exp_data = own2 ? data2 : data1;
          exp_g = own2 ? 2'b10 : 2'b01;
        end
        tick;
        total++;
        if (exp_now) begin
          granted = 1;
          if ({cmd_valid, grant, cmd} !== {1'b1, exp_g, exp_data}) begin
            bad++; $display("FAIL rnd_grant it=%0d: got %h want %h", it, {cmd_valid, grant, cmd}, {1'b1, exp_g, exp_data});
          end
        end else if ({cmd_valid, grant} !== 3'b000) begin
          bad++; $display("FAIL rnd_no_grant it=%0d: got %b want 000", it, {cmd_valid, grant});
        end
        cyc++;
      end
      if (!granted) begin
        total++; bad++;
        $display("FAIL rnd_grant_bound it=%0d: got no grant want grant within 50 cycles", it);
        return;
      end
      if (coin(2)) begin data1 = $urandom; data2 = $urandom; end
      if (coin(4)) begin if (own2) req2 = 0; else req1 = 0; end
      d = $urandom_range(T + 1, 1);
      exp_n = (d <= T) ? d : T;
      done = coin(2);
      busy = coin(2);
      for (int w = 1; w <= exp_n; w++) begin
        tick;
        total++;
        if ({cmd_valid, cmd, grant, ack1, ack2, timeout} !== {1'b0, 32'h0, exp_g, 3'b000}) begin
          bad++; $display("FAIL rnd_wait it=%0d w=%0d: got %h want %h", it, w,
                          {cmd_valid, cmd, grant, ack1, ack2, timeout}, {1'b0, 32'h0, exp_g, 3'b000});
        end
        done = (w == d);
        busy = coin(2);
      end
      tick;
      total++;
      if ({cmd_valid, grant, ack2, ack1, timeout} !== {1'b0, exp_g, own2, !own2, (d > T)}) begin
        bad++; $display("FAIL rnd_ack it=%0d d=%0d: got %b want %b", it, d,
                        {cmd_valid, grant, ack2, ack1, timeout}, {1'b0, exp_g, own2, !own2, (d > T)});
      end
      done = (d == T + 1);
      m_last2 = own2;
      if (!coin(4)) begin if (own2) req2 = 0; else req1 = 0; end
      tick;
      total++;
      if ({cmd_valid, cmd, grant, ack1, ack2, timeout} !== 38'h0) begin
        bad++; $display("FAIL rnd_idle it=%0d: got %h want 0", it, {cmd_valid, cmd, grant, ack1, ack2, timeout});
      end
    end
    req1 = 0; req2 = 0; busy = 0; done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; total = 0; bad = 0;
    rst = 1; req1 = 0; req2 = 0; busy = 0; done = 0; data1 = '0; data2 = '0;
    test_reset;
    test_single;
    test_alternation;
    test_busy;
    test_timeout;
    test_reset_in_wait;
    test_done_boundary;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
